// File: rtl/wb_window_decoder_pkg.sv
// Shared definitions for the Wishbone window decoder.
// Holds the fault cause codes, the decoder FSM state encoding, and width
// helpers used by the top level and the window matcher.
package wb_window_decoder_pkg;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_UNMAPPED = 2'b01,
        FAULT_TIMEOUT  = 2'b10,
        FAULT_TGT_ERR  = 2'b11
    } fault_cause_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        MISS  = 2'b10,
        ABORT = 2'b11
    } state_e;

    // Target index width; a single target still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog timer width; a disabled watchdog keeps a one-bit stub.
    function automatic int tmr_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_window_decoder_if.sv
// Wishbone bundle around the window decoder.
// Master side (m_wb_*): request from the arbiter and the response back to it.
// Target side (s_wb_*): one-hot cyc/stb per target, broadcast request fields,
// per-target ack/err and a flat read-data vector (slice k = target k).
// Modport slave is the decoder's view; modport master is the environment's.
interface wb_window_decoder_if #(
    parameter int N_TGT  = 4,
    parameter int ADDR_W = 24,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2
);
    logic                    m_wb_cyc;
    logic                    m_wb_stb;
    logic                    m_wb_we;
    logic [ADDR_W-1:0]       m_wb_adr;
    logic [DATA_W-1:0]       m_wb_o_dat;
    logic [SEL_W-1:0]        m_wb_sel;
    logic                    m_wb_4_burst;
    logic                    m_wb_8_burst;
    logic                    m_wb_ack;
    logic                    m_wb_err;
    logic [DATA_W-1:0]       m_wb_i_dat;

    logic [N_TGT-1:0]        s_wb_cyc;
    logic [N_TGT-1:0]        s_wb_stb;
    logic                    s_wb_we;
    logic [ADDR_W-1:0]       s_wb_adr;
    logic [DATA_W-1:0]       s_wb_o_dat;
    logic [SEL_W-1:0]        s_wb_sel;
    logic                    s_wb_4_burst;
    logic                    s_wb_8_burst;
    logic [N_TGT-1:0]        s_wb_ack;
    logic [N_TGT-1:0]        s_wb_err;
    logic [N_TGT*DATA_W-1:0] s_wb_i_dat;

    modport slave (
        input  m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_o_dat, m_wb_sel,
               m_wb_4_burst, m_wb_8_burst,
        output m_wb_ack, m_wb_err, m_wb_i_dat,
        output s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_o_dat, s_wb_sel,
               s_wb_4_burst, s_wb_8_burst,
        input  s_wb_ack, s_wb_err, s_wb_i_dat
    );

    modport master (
        output m_wb_cyc, m_wb_stb, m_wb_we, m_wb_adr, m_wb_o_dat, m_wb_sel,
               m_wb_4_burst, m_wb_8_burst,
        input  m_wb_ack, m_wb_err, m_wb_i_dat,
        input  s_wb_cyc, s_wb_stb, s_wb_we, s_wb_adr, s_wb_o_dat, s_wb_sel,
               s_wb_4_burst, s_wb_8_burst,
        output s_wb_ack, s_wb_err, s_wb_i_dat
    );

endinterface

// File: rtl/wb_window_match.sv
// Base/mask address window comparator array with a priority encoder.
// Ports: adr (address to decode), hit (any window matched),
// idx (lowest-index matching window, 0 when no hit). Purely combinational.
module wb_window_match
    import wb_window_decoder_pkg::*;
#(
    parameter int                      N_TGT    = 4,
    parameter int                      ADDR_W   = 24,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = '0,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = '0
) (
    input  logic [ADDR_W-1:0]           adr,
    output logic                        hit,
    output logic [idx_width(N_TGT)-1:0] idx
);
    localparam int IDX_W = idx_width(N_TGT);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        // Walk from the top down so the lowest matching index is the last
        // one written and therefore wins.
        for (int k = N_TGT - 1; k >= 0; k--) begin
            if ((adr & TGT_MASK[k*ADDR_W +: ADDR_W]) ==
                (TGT_BASE[k*ADDR_W +: ADDR_W] & TGT_MASK[k*ADDR_W +: ADDR_W])) begin
                hit = 1'b1;
                idx = k[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_window_decoder.sv
// Wishbone target decoder with bus watchdog.
// Routes one master port to N_TGT targets chosen by base/mask windows, locks
// the chosen target for the whole cyc, and terminates unmapped or hung
// accesses with err. The first fault (cause + address) is held until cleared.
// Ports: i_clk, i_rst_n (async, active-low), bus (decoder side of the
// Wishbone bundle), i_fault_clr, o_fault_valid/o_fault_cause/o_fault_adr.
module wb_window_decoder
    import wb_window_decoder_pkg::*;
#(
    parameter int                      N_TGT    = 4,
    parameter int                      ADDR_W   = 24,
    parameter int                      DATA_W   = 16,
    parameter int                      SEL_W    = 2,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_BASE = '0,
    parameter logic [N_TGT*ADDR_W-1:0] TGT_MASK = '0,
    parameter int                      TMO_CYC  = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    wb_window_decoder_if.slave   bus,
    input  logic                 i_fault_clr,
    output logic                 o_fault_valid,
    output logic [1:0]           o_fault_cause,
    output logic [ADDR_W-1:0]    o_fault_adr
);
    localparam int              IDX_W   = idx_width(N_TGT);
    localparam int              TMR_W   = tmr_width(TMO_CYC);
    localparam logic [TMR_W-1:0] TMO_VAL = TMR_W'(TMO_CYC);
    localparam logic [TMR_W-1:0] TMR_MAX = '1;

    state_e              state, state_nxt;
    logic [IDX_W-1:0]    tsel;
    logic [TMR_W-1:0]    timer;
    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                req;
    logic                sel_ack, sel_err;
    logic [DATA_W-1:0]   sel_dat;
    logic                tmo_hit;
    logic                fwd;
    logic                fault_evt;
    fault_cause_e        fault_new;
    fault_cause_e        fault_cause;

    wb_window_match #(
        .N_TGT    (N_TGT),
        .ADDR_W   (ADDR_W),
        .TGT_BASE (TGT_BASE),
        .TGT_MASK (TGT_MASK)
    ) u_match (
        .adr (bus.m_wb_adr),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign req = bus.m_wb_cyc & bus.m_wb_stb;

    // Response mux from the locked target.
    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < N_TGT; k++) begin
            if (tsel == k[IDX_W-1:0]) begin
                sel_ack = bus.s_wb_ack[k];
                sel_err = bus.s_wb_err[k];
                sel_dat = bus.s_wb_i_dat[k*DATA_W +: DATA_W];
            end
        end
    end

    // The timeout cycle withdraws the target strobes so a hung target cannot
    // race the err with a last-moment ack.
    assign tmo_hit = (TMO_CYC != 0) && (state == BUSY) && req && (timer == TMO_VAL);
    assign fwd     = (state == BUSY) && !tmo_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        bus.s_wb_cyc       = '0;
        bus.s_wb_stb       = '0;
        bus.m_wb_ack       = fwd & sel_ack;
        bus.m_wb_err       = (fwd & sel_err) | tmo_hit | (state == MISS);
        bus.m_wb_i_dat     = fwd ? sel_dat : '0;
        // Broadcast fields are only driven while a target is selected so the
        // target side is quiet whenever no transfer is being forwarded.
        bus.s_wb_we        = fwd & bus.m_wb_we;
        bus.s_wb_adr       = fwd ? bus.m_wb_adr : '0;
        bus.s_wb_o_dat     = fwd ? bus.m_wb_o_dat : '0;
        bus.s_wb_sel       = fwd ? bus.m_wb_sel : {SEL_W{1'b0}};
        bus.s_wb_4_burst   = fwd & bus.m_wb_4_burst;
        bus.s_wb_8_burst   = fwd & bus.m_wb_8_burst;
        for (int k = 0; k < N_TGT; k++) begin
            if (fwd && (tsel == k[IDX_W-1:0])) begin
                bus.s_wb_cyc[k] = bus.m_wb_cyc;
                bus.s_wb_stb[k] = bus.m_wb_stb;
            end
        end
        case (state)
            IDLE:    if (req) state_nxt = dec_hit ? BUSY : MISS;
            BUSY:    if (tmo_hit) state_nxt = ABORT;
                     else if (!bus.m_wb_cyc) state_nxt = IDLE;
            MISS:    state_nxt = IDLE;
            ABORT:   if (!bus.m_wb_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Target lock and watchdog timer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tsel  <= '0;
            timer <= '0;
        end else if ((state == IDLE) && req && dec_hit) begin
            tsel  <= dec_idx;
            timer <= '0;
        end else if (state == BUSY) begin
            if (sel_ack || sel_err) begin
                timer <= '0;
            end else if (bus.m_wb_stb && (timer != TMR_MAX)) begin
                timer <= timer + 1'b1;
            end
        end
    end

    // Fault events are taken in the cycle the err is presented to the master.
    always_comb begin
        fault_evt = 1'b0;
        fault_new = FAULT_NONE;
        if (state == MISS) begin
            fault_evt = 1'b1;
            fault_new = FAULT_UNMAPPED;
        end else if (tmo_hit) begin
            fault_evt = 1'b1;
            fault_new = FAULT_TIMEOUT;
        end else if (fwd && sel_err) begin
            fault_evt = 1'b1;
            fault_new = FAULT_TGT_ERR;
        end
    end

    // A clear coinciding with a new fault lets the new fault in.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_fault_valid <= 1'b0;
            fault_cause   <= FAULT_NONE;
            o_fault_adr   <= '0;
        end else if (fault_evt && (!o_fault_valid || i_fault_clr)) begin
            o_fault_valid <= 1'b1;
            fault_cause   <= fault_new;
            o_fault_adr   <= bus.m_wb_adr;
        end else if (i_fault_clr) begin
            o_fault_valid <= 1'b0;
            fault_cause   <= FAULT_NONE;
            o_fault_adr   <= '0;
        end
    end

    assign o_fault_cause = fault_cause;

endmodule

// File: tb/tb_wb_window_decoder.sv
// Scoreboard bench for wb_window_decoder: two targets, watchdog of 8 cycles.
module tb_wb_window_decoder;
    import wb_window_decoder_pkg::*;

    localparam int N_TGT = 2;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int SEL_W = 2;
    localparam int TMO = 8;
    localparam logic [47:0] BASE = {24'h800000, 24'h001000};
    localparam logic [47:0] MASK = {24'hFF0000, 24'hFFFFF0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault_clr = 1'b0;
    logic fault_valid;
    logic [1:0] fault_cause;
    logic [23:0] fault_adr;

    wb_window_decoder_if #(.N_TGT(N_TGT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

    wb_window_decoder #(
        .N_TGT(N_TGT), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
        .TGT_BASE(BASE), .TGT_MASK(MASK), .TMO_CYC(TMO)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .i_fault_clr(fault_clr),
        .o_fault_valid(fault_valid), .o_fault_cause(fault_cause), .o_fault_adr(fault_adr)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Reference model state.
    typedef struct {bit is_err; logic [15:0] dat; int at;} resp_t;
    resp_t exp_q[$];
    logic [23:0] win_base [2] = '{24'h001000, 24'h800000};
    logic [23:0] win_mask [2] = '{24'hFFFFF0, 24'hFF0000};
    bit m_fv = 0;
    logic [1:0] m_fc = 2'b00;
    logic [23:0] m_fa = '0;
    logic [1:0] allowed = '0;

    function automatic int ref_decode(input logic [23:0] a);
        for (int k = 0; k < 2; k++)
            if ((a & win_mask[k]) == (win_base[k] & win_mask[k])) return k;
        return -1;
    endfunction

    function automatic void model_fault(input logic [1:0] cause, input logic [23:0] a, input bit clr);
        if (!m_fv || clr) begin
            m_fv = 1;
            m_fc = cause;
            m_fa = a;
        end
    endfunction

    // Target models: respond `lat` cycles after first seeing stb with
    // data = base ^ adr[1:0], or err instead of ack.
    int tgt_lat [2] = '{0, 0};
    bit tgt_err [2] = '{0, 0};
    logic [15:0] tgt_dat [2] = '{16'h0, 16'h0};
    bit late_ack = 0;

    initial begin
        int cnt [2];
        logic [1:0] ack_v, err_v;
        cnt = '{0, 0};
        bus.s_wb_ack = '0;
        bus.s_wb_err = '0;
        bus.s_wb_i_dat = '0;
        forever begin
            @(posedge clk);
            #2;
            ack_v = '0;
            err_v = '0;
            for (int k = 0; k < 2; k++) begin
                if (bus.s_wb_stb[k]) begin
                    if (cnt[k] == tgt_lat[k]) begin
                        ack_v[k] = !tgt_err[k];
                        err_v[k] = tgt_err[k];
                        cnt[k] = 0;
                    end else begin
                        cnt[k]++;
                    end
                end else begin
                    cnt[k] = 0;
                end
            end
            ack_v[0] = ack_v[0] | late_ack;
            bus.s_wb_ack = ack_v;
            bus.s_wb_err = err_v;
            bus.s_wb_i_dat = {tgt_dat[1] ^ {14'b0, bus.s_wb_adr[1:0]},
                              tgt_dat[0] ^ {14'b0, bus.s_wb_adr[1:0]}};
        end
    end

    // Monitor: pops one expectation per master response.
    initial begin
        resp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (((bus.s_wb_cyc | bus.s_wb_stb) & ~allowed) != 0)
                    check("stray_strobe", 32'(bus.s_wb_cyc | bus.s_wb_stb), 32'(allowed));
                if (bus.m_wb_ack || bus.m_wb_err) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", {bus.m_wb_ack, bus.m_wb_err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_is_err", bus.m_wb_err, e.is_err);
                        check("resp_ack", bus.m_wb_ack, !e.is_err);
                        check("resp_cycle", cyc_n, e.at);
                        if (!e.is_err) check("resp_dat", bus.m_wb_i_dat, e.dat);
                    end
                end
            end
        end
    end

    task automatic drop_master();
        bus.m_wb_cyc = 0;
        bus.m_wb_stb = 0;
        bus.m_wb_4_burst = 0;
        bus.m_wb_8_burst = 0;
    endtask

    task automatic check_fault(input string tag);
        check({tag, "_fault_valid"}, fault_valid, m_fv);
        check({tag, "_fault_cause"}, fault_cause, m_fc);
        check({tag, "_fault_adr"}, fault_adr, m_fa);
    endtask

    task automatic clear_fault();
        fault_clr = 1;
        @(posedge clk); #1;
        fault_clr = 0;
        m_fv = 0; m_fc = 2'b00; m_fa = '0;
        @(posedge clk); #1;
        check_fault("clear");
    endtask

    // One master transaction; starts and ends 1 time unit after a posedge.
    task automatic xfer(input logic [23:0] adr0, input int beats, input int lat,
                        input bit terr, input logic [15:0] dat, input bit clr);
        int tgt, c, r;
        bit got;
        logic [23:0] a;
        tgt = ref_decode(adr0);
        if (tgt >= 0) begin
            tgt_lat[tgt] = lat;
            tgt_err[tgt] = terr;
            tgt_dat[tgt] = dat;
            allowed = 2'(1 << tgt);
        end else begin
            allowed = '0;
        end
        if (tgt < 0 || lat >= TMO || terr) beats = 1;
        bus.m_wb_cyc = 1;
        bus.m_wb_stb = 1;
        bus.m_wb_adr = adr0;
        bus.m_wb_we = 1'($urandom_range(0, 1));
        bus.m_wb_o_dat = 16'($urandom);
        bus.m_wb_sel = 2'($urandom);
        bus.m_wb_4_burst = (beats == 4);
        c = cyc_n;
        r = c;
        for (int b = 0; b < beats; b++) begin
            a = adr0 + 24'(b);
            if (tgt < 0) begin
                exp_q.push_back('{is_err: 1'b1, dat: 16'h0, at: c + 1});
                model_fault(FAULT_UNMAPPED, a, clr);
            end else if (lat >= TMO) begin
                exp_q.push_back('{is_err: 1'b1, dat: 16'h0, at: c + 1 + TMO});
                model_fault(FAULT_TIMEOUT, a, 0);
            end else begin
                r = r + 1 + lat;
                exp_q.push_back('{is_err: terr, dat: dat ^ {14'b0, a[1:0]}, at: r});
                if (terr) model_fault(FAULT_TGT_ERR, a, 0);
            end
        end
        if (clr) begin
            @(posedge clk); #1;
            fault_clr = 1;
        end
        for (int b = 0; b < beats; b++) begin
            got = 0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                got = bus.m_wb_ack | bus.m_wb_err;
            end
            if (!got) begin
                n_chk++;
                n_fail++;
                $display("FAIL resp_wait: no response within 40 cycles, required beat %0d of 0x%0h", b, adr0);
                exp_q.delete();
                @(posedge clk); #1;
                fault_clr = 0;
                drop_master();
                break;
            end
            @(posedge clk); #1;
            fault_clr = 0;
            if (b < beats - 1) begin
                bus.m_wb_adr = adr0 + 24'(b + 1);
                bus.m_wb_o_dat = 16'($urandom);
            end else if (tgt >= 0 && lat >= TMO) begin
                late_ack = 1;
                @(negedge clk);
                check("abort_ack_ignored", bus.m_wb_ack, 0);
                check("abort_cyc_low", 32'(bus.s_wb_cyc), 0);
                @(posedge clk); #1;
                late_ack = 0;
                drop_master();
            end else begin
                drop_master();
            end
        end
        repeat (2) @(posedge clk);
        #1;
        allowed = '0;
        check_fault("xfer");
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int kind;
        logic [23:0] a;
        bus.m_wb_adr = '0;
        bus.m_wb_we = 0;
        bus.m_wb_o_dat = '0;
        bus.m_wb_sel = '0;
        drop_master();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_m_ack", bus.m_wb_ack, 0);
        check("rst_m_err", bus.m_wb_err, 0);
        check("rst_m_dat", bus.m_wb_i_dat, 0);
        check("rst_s_cyc", 32'(bus.s_wb_cyc), 0);
        check("rst_s_stb", 32'(bus.s_wb_stb), 0);
        check("rst_s_adr", bus.s_wb_adr, 0);
        check_fault("rst");
        rst_n = 1;
        @(posedge clk); #1;

        // Directed scenarios.
        xfer(24'h800004, 1, 2, 0, 16'hBEEF, 0);   // read, ack 3 cycles after stb
        xfer(24'h400000, 1, 0, 0, 16'h0, 0);      // unmapped -> cause 01
        xfer(24'h001002, 1, TMO, 0, 16'h0, 0);    // timeout while fault held
        clear_fault();
        xfer(24'h001003, 1, TMO, 0, 16'h0, 0);    // timeout -> cause 10
        xfer(24'h123456, 1, 0, 0, 16'h0, 1);      // clear with new fault
        xfer(24'h800000, 4, 0, 0, 16'hA5A0, 0);   // 4-beat burst, one ack per cycle
        xfer(24'h00100C, 1, TMO - 1, 0, 16'h1234, 0); // latest legal ack
        xfer(24'h800100, 3, 2, 0, 16'h5550, 0);   // burst with wait states
        xfer(24'h800200, 1, 1, 1, 16'h0, 0);      // target err, fault held
        clear_fault();
        xfer(24'h800201, 1, 1, 1, 16'h0, 0);      // target err -> cause 11

        // Asynchronous reset in the middle of a forwarded access.
        tgt_lat[1] = 20;
        tgt_err[1] = 0;
        allowed = 2'b10;
        bus.m_wb_cyc = 1;
        bus.m_wb_stb = 1;
        bus.m_wb_adr = 24'h800010;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_stb", 32'(bus.s_wb_stb), 32'h2);
        #2;
        rst_n = 0;
        #1;
        check("arst_m_ack", bus.m_wb_ack, 0);
        check("arst_m_err", bus.m_wb_err, 0);
        check("arst_m_dat", bus.m_wb_i_dat, 0);
        check("arst_s_cyc", 32'(bus.s_wb_cyc), 0);
        check("arst_s_stb", 32'(bus.s_wb_stb), 0);
        check("arst_s_adr", bus.s_wb_adr, 0);
        m_fv = 0; m_fc = 2'b00; m_fa = '0;
        check_fault("arst");
        drop_master();
        allowed = '0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        xfer(24'h800010, 1, 0, 0, 16'h7E57, 0);   // restart from IDLE

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                a = 24'h001000 | 24'($urandom_range(0, 15));
                xfer(a, 1, $urandom_range(0, 5), ($urandom_range(0, 7) == 0), 16'($urandom), 0);
            end else if (kind <= 7) begin
                a = 24'h800000 | 24'($urandom_range(0, 16'hFFF0));
                xfer(a, $urandom_range(1, 4), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                     16'($urandom), 0);
            end else if (kind == 8) begin
                a = 24'($urandom);
                xfer(a, 1, $urandom_range(0, 3), 0, 16'($urandom), ($urandom_range(0, 2) == 0));
            end else begin
                a = 24'h001000 | 24'($urandom_range(0, 15));
                xfer(a, 1, TMO + $urandom_range(0, 5), 0, 16'h0, 0);
            end
            if ($urandom_range(0, 4) == 0) clear_fault();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_window_decoder.md
# wb_window_decoder

Parametrised Wishbone target decoder with bus watchdog for the outer interconnect. Routes one master port (arbiter output) to `N_TGT` target ports selected by base/mask address windows, locks the selected target for the whole `cyc`, and terminates unmapped or hung accesses with `err`. The first fault is captured for software and debug. It generalises the fixed `tsel` chain into a table-driven block with a timeout, which the fixed chain does not have.

## Interface
- `N_TGT`, 4: number of target ports (1..8).
- `ADDR_W`, 24: Wishbone address width.
- `DATA_W`, 16: Wishbone data width.
- `SEL_W`, 2: byte-select width.
- `TGT_BASE`, 0: flat `N_TGT*ADDR_W` vector; slice k is the base of target k.
- `TGT_MASK`, 0: flat `N_TGT*ADDR_W` vector; target k hits when `(adr & mask_k) == (base_k & mask_k)`.
- `TMO_CYC`, 255: watchdog limit in cycles; 0 disables the watchdog.
- `i_clk` in 1: core clock (single clock domain).
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `m_wb_cyc`, `m_wb_stb`, `m_wb_we` in 1 each: master request.
- `m_wb_adr` in `ADDR_W`; `m_wb_o_dat` in `DATA_W`; `m_wb_sel` in `SEL_W`; `m_wb_4_burst`, `m_wb_8_burst` in 1 each.
- `m_wb_ack`, `m_wb_err` out 1 each; `m_wb_i_dat` out `DATA_W`: master response.
- `s_wb_cyc`, `s_wb_stb` out `N_TGT`: per-target one-hot strobes.
- `s_wb_we`, `s_wb_adr`, `s_wb_o_dat`, `s_wb_sel`, `s_wb_4_burst`, `s_wb_8_burst` out: broadcast copies of the master fields.
- `s_wb_ack`, `s_wb_err` in `N_TGT`; `s_wb_i_dat` in `N_TGT*DATA_W`: target responses.
- `i_fault_clr` in 1: clears the fault capture.
- `o_fault_valid` out 1; `o_fault_cause` out 2; `o_fault_adr` out `ADDR_W`: fault capture.

## Operation
- FSM states: IDLE, BUSY, MISS, ABORT.
- IDLE
  - On `m_wb_cyc & m_wb_stb`, decode `m_wb_adr`; the lowest-index hit wins.
  - On a hit: register target index `tsel`, clear the timer, go to BUSY.
  - On no hit: go to MISS.
- BUSY
  - `s_wb_cyc[tsel] = m_wb_cyc`; `s_wb_stb[tsel] = m_wb_stb`.
  - `m_wb_ack`, `m_wb_err` and `m_wb_i_dat` are muxed combinationally from `tsel`.
  - The decode is locked for the whole `cyc`; later beats go to `tsel` whatever their address (bursts).
  - Timer: increments while `m_wb_stb & ~ack & ~err`; clears on ack or err.
  - On timer reaching `TMO_CYC` (nonzero): `m_wb_err=1` for that cycle, the target sees no `stb` and no `cyc`, go to ABORT.
  - A target `err` is passed through and recorded as cause 2'b11.
  - `m_wb_cyc` low: go to IDLE.
- MISS: `m_wb_err=1` for one cycle, no target strobed, go to IDLE.
- ABORT: all `s_wb_cyc` low, late target acks are ignored; go to IDLE when `m_wb_cyc` is low.
- Fault capture
  - The first fault sets `o_fault_valid` and latches the cause and the faulting address.
  - Cause codes: 01 unmapped, 10 timeout, 11 target err.
  - Later faults do not overwrite a held fault.
  - `i_fault_clr` clears the capture; if a fault occurs in the same cycle as the clear, the new fault is captured.
- Outside BUSY: `m_wb_ack=0` and `m_wb_i_dat=0`.

## Timing
- Reset values: state IDLE; all outputs 0; `tsel` 0; timer 0; fault capture cleared.
- Decode latency: a target first sees `stb` one cycle after the master raises it; the ack is returned in the same cycle as `s_wb_ack`.
- Burst beats after the first: zero added latency.
- Unmapped access: `m_wb_err` is asserted exactly one cycle after the request.
- Timeout: `m_wb_err` is asserted `TMO_CYC` cycles after the target first sees `stb`, with no response.
- Timer width: `$clog2(TMO_CYC+1)`; saturates and never wraps.
- Reset deassertion mid-transfer: the block restarts in IDLE; the master must re-issue its request.

## Structure
- Shared package holds:
  - cause codes `FAULT_NONE`, `FAULT_UNMAPPED`, `FAULT_TIMEOUT`, `FAULT_TGT_ERR`;
  - state encoding.
- Sub-module `wb_window_match`: parametrised base/mask comparator array with a priority encoder.
  - Outputs: `hit`, `idx`.
  - Purely combinational; instantiated once.

## Test plan
- Config: `N_TGT=2`; windows 0x001000/0xFFFFF0 and 0x800000/0xFF0000; `TMO_CYC=8`.
- Read 0x800004, target 1 acks after 2 cycles with 0xBEEF -> master sees ack with 0xBEEF three cycles after its `stb`; `s_wb_stb[0]` never asserted.
- Read 0x400000 (unmapped) -> `m_wb_err` one cycle later; fault valid, cause 01, address 0x400000.
- Target 0 never acks -> `m_wb_err` 8 cycles after forwarding, cause 10; a late `s_wb_ack[0]` in ABORT is ignored.
- 4-beat burst to target 1, beats at 0x800000..0x800003 with one ack per cycle -> four master acks, target locked for the whole `cyc`.
- Second fault while the capture is held -> first fault retained; `i_fault_clr` in the same cycle as a new fault -> new fault captured.
- `i_rst_n` pulsed low mid-BUSY -> all outputs 0 asynchronously; state IDLE.
